// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and the load-extension helper for the data-memory
// responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } state_e;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      size_e       size;
      logic        sgn;
      logic [31:0] wdata;
   } req_t;

   function automatic logic [31:0] extend(
      input logic [31:0] data,
      input size_e       size,
      input logic        sgn
   );
      logic [31:0] r;
      case (size)
         SZ_BYTE: r = {{24{sgn & data[7]}}, data[7:0]};
         SZ_HALF: r = {{16{sgn & data[15]}}, data[15:0]};
         default: r = data;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: big-endian byte-lane steering for sized loads and stores.
// Half ignores off[0]; word and reserved sizes ignore off entirely.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  size_e       size,
   input  logic [1:0]  off,
   input  logic        sgn,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] merged,
   output logic [31:0] rdata
);

   logic [4:0]  sh;
   logic [31:0] wsh;

   // Byte offset 0 lives in bits 31:24, so the lane shift is (3 - off) bytes.
   always_comb begin
      be = 4'b1111;
      sh = 5'd0;
      case (size)
         SZ_BYTE: begin
            be = 4'b0001 << ~off;
            sh = {~off, 3'b000};
         end
         SZ_HALF: begin
            be = off[1] ? 4'b0011 : 4'b1100;
            sh = {~off[1], 4'b0000};
         end
         default: ;
      endcase
   end

   assign wsh   = wdata << sh;
   assign rdata = extend(rword >> sh, size, sgn);

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         merged[8*k +: 8] = be[k] ? wsh[8*k +: 8] : rword[8*k +: 8];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle sized load/store responder, one request in flight.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned and reserved-size accesses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q;
   req_t          req_in, req_q, acc;
   logic          accept, do_access, fault, wr_en;
   logic [AW-1:0] idx;
   logic [31:0]   idx_word, rword, merged, ld_data;
   logic [3:0]    be;
   logic          unused_addr;

   // Words are stored XORed with their index so a zeroed array reads as mem[i] = i.
   logic [31:0]   mem [DEPTH_WORDS];

   assign req_in = '{
      we:    req_we,
      addr:  req_addr,
      size:  size_e'(req_size),
      sgn:   req_signed,
      wdata: req_wdata
   };

   assign req_ready   = (state_q == IDLE);
   assign rsp_valid   = (state_q == RESP);
   assign accept      = req_valid && req_ready;
   assign acc         = (state_q == IDLE) ? req_in : req_q;
   assign idx         = acc.addr[2 +: AW];
   assign idx_word    = 32'(idx);
   assign rword       = mem[idx] ^ idx_word;
   assign unused_addr = ^acc.addr[31:2+AW];

`ifdef DMEM_ALIGN_CHECK_EN
   always_comb begin
      case (acc.size)
         SZ_HALF: fault = acc.addr[0];
         SZ_WORD: fault = |acc.addr[1:0];
         SZ_RSVD: fault = 1'b1;
         default: fault = 1'b0;
      endcase
   end
`else
   assign fault = 1'b0;
`endif

   dmem_lane_align u_align (
      .size   (acc.size),
      .off    (acc.addr[1:0]),
      .sgn    (acc.sgn),
      .wdata  (acc.wdata),
      .rword  (rword),
      .be     (be),
      .merged (merged),
      .rdata  (ld_data)
   );

   always_comb begin
      state_d   = state_q;
      do_access = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  do_access = 1'b1;
                  state_d   = RESP;
               end else begin
                  state_d   = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt_q == CW'(1)) begin
               do_access = 1'b1;
               state_d   = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         req_q     <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            cnt_q <= CW'(LATENCY - 1);
            req_q <= req_in;
         end else if (state_q == BUSY) begin
            cnt_q <= cnt_q - CW'(1);
         end
         if (do_access) begin
            rsp_rdata <= (acc.we || fault) ? '0 : ld_data;
            rsp_err   <= fault;
         end
      end
   end

   // A store pending when reset hits must leave the array untouched.
   assign wr_en = do_access && acc.we && !fault && !rst;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < 4; k++) begin
            if (be[k]) mem[idx][8*k +: 8] <= merged[8*k +: 8] ^ idx_word[8*k +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against
// a byte-level reference model of the data memory.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   logic        a_valid;
   logic [31:0] a_addr;
   logic        a1_ready, a1_rv, a1_err;
   logic        a3_ready, a3_rv, a3_err;
   logic [31:0] a1_rd, a3_rd;

   int nvec = 0;
   int nerr = 0;
   logic [31:0] mm [256];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(a_valid), .req_ready(a1_ready), .req_we(1'b0),
      .req_addr(a_addr), .req_size(2'b10), .req_signed(1'b0),
      .req_wdata(32'h0), .rsp_valid(a1_rv), .rsp_ready(1'b1),
      .rsp_rdata(a1_rd), .rsp_err(a1_err)
   );

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (
      .clk(clk), .rst(rst),
      .req_valid(a_valid), .req_ready(a3_ready), .req_we(1'b0),
      .req_addr(a_addr), .req_size(2'b10), .req_signed(1'b0),
      .req_wdata(32'h0), .rsp_valid(a3_rv), .rsp_ready(1'b1),
      .rsp_rdata(a3_rd), .rsp_err(a3_err)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory as an array of big-endian words; a sized access touches a run of
   // nb bytes starting at byte st, i.e. bits 8*(4-st-nb) upward.
   task automatic model(input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic sgn,
                        input logic [31:0] wdata,
                        output logic [31:0] r, output logic e);
      int w, off, sz, nb, st, sh;
      logic [63:0] m;
      logic [31:0] v, mask;
      w   = int'(addr[9:2]);
      off = int'(addr[1:0]);
      sz  = int'(size);
`ifdef DMEM_ALIGN_CHECK_EN
      e = (sz == 3) || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
`else
      e = 1'b0;
      if (sz == 3) sz = 2;
`endif
      nb   = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
      st   = off - off % nb;
      sh   = 8 * (4 - st - nb);
      m    = (64'd1 << (8 * nb)) - 64'd1;
      mask = m[31:0];
      r    = 32'h0;
      if (!e && we) begin
         mm[w] = (mm[w] & ~(mask << sh)) | ((wdata & mask) << sh);
      end else if (!e) begin
         v = (mm[w] >> sh) & mask;
         if (sgn && nb < 4 && v[8*nb-1]) v = v | ~mask;
         r = v;
      end
   endtask

   task automatic op(input string tag, input logic we, input logic [31:0] addr,
                     input logic [1:0] size, input logic sgn,
                     input logic [31:0] wdata, input int stall,
                     output logic [31:0] r, output logic e);
      logic [31:0] mr;
      logic        me;
      int          n;
      model(we, addr, size, sgn, wdata, mr, me);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_size   = size;
      req_signed = sgn;
      req_wdata  = wdata;
      rsp_ready  = (stall == 0);
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_rdy"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid  = (stall > 0);
      req_we     = 1'($urandom);
      req_addr   = $urandom;
      req_size   = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom);
      req_wdata  = $urandom;
      n = 1;
      while (!rsp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      r = rsp_rdata;
      e = rsp_err;
      check({tag, "_lat"}, 32'(n), 32'd2);
      check({tag, "_data"}, r, mr);
      check({tag, "_err"}, 32'(e), 32'(me));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check({tag, "_hold_vr"}, 32'({rsp_valid, req_ready}), 32'd2);
         check({tag, "_hold_d"}, rsp_rdata, mr);
      end
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check({tag, "_idle"}, 32'({rsp_valid, req_ready}), 32'd1);
   endtask

   initial begin
      logic [31:0] r;
      logic        e;
      int          acc1, acc3, bad;
      logic        t_we, t_sgn;
      logic [31:0] t_addr, t_wd;
      logic [1:0]  t_sz;
      int          t_st;

      for (int i = 0; i < 256; i++) mm[i] = 32'(i);
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = '0;
      req_size   = 2'b10;
      req_signed = 1'b0;
      req_wdata  = '0;
      rsp_ready  = 1'b1;
      a_valid    = 1'b0;
      a_addr     = 32'h404;

      repeat (3) @(posedge clk);
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      rst = 1'b0;
      check("rst_req_ready", 32'(req_ready), 32'd1);

      op("p1_lw", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, r, e);
      check("p1_rdata", r, 32'h4);
      check("p1_err", 32'(e), 32'd0);

      op("p2_sw", 1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, 0, r, e);
      check("p2_sw_rdata", r, 32'h0);
      op("p2_lbu21", 1'b0, 32'h21, 2'b00, 1'b0, 32'h0, 0, r, e);
      check("p2_lbu21_v", r, 32'h22);
      op("p2_lbu23", 1'b0, 32'h23, 2'b00, 1'b0, 32'h0, 0, r, e);
      check("p2_lbu23_v", r, 32'h44);
      op("p2_sb", 1'b1, 32'h20, 2'b00, 1'b0, 32'h80, 0, r, e);
      op("p2_lb", 1'b0, 32'h20, 2'b00, 1'b1, 32'h0, 0, r, e);
      check("p2_lb_v", r, 32'hFFFFFF80);
      op("p2_lw", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, r, e);
      check("p2_lw_v", r, 32'h80223344);

      op("p3_bp", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 3, r, e);
      check("p3_bp_v", r, 32'h80223344);

      op("p4_sw", 1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, 0, r, e);
      op("p4_lw22", 1'b0, 32'h22, 2'b10, 1'b0, 32'h0, 0, r, e);
`ifdef DMEM_ALIGN_CHECK_EN
      check("p4_lw22_v", r, 32'h0);
      check("p4_lw22_e", 32'(e), 32'd1);
`else
      check("p4_lw22_v", r, 32'h11223344);
      check("p4_lw22_e", 32'(e), 32'd0);
`endif
      op("p4_sh21", 1'b1, 32'h21, 2'b01, 1'b0, 32'h0000AABB, 0, r, e);
      op("p4_lw20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, r, e);
`ifdef DMEM_ALIGN_CHECK_EN
      check("p4_lw20_v", r, 32'h11223344);
`else
      check("p4_lw20_v", r, 32'hAABB3344);
`endif

      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_addr   = 32'h40;
      req_size   = 2'b10;
      req_signed = 1'b0;
      req_wdata  = 32'hDEADBEEF;
      @(posedge clk); #1;
      check("p5_busy", 32'(req_ready), 32'd0);
      rst       = 1'b1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("p5_rst_v1", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      check("p5_rst_v2", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      check("p5_rel_ready", 32'(req_ready), 32'd1);
      op("p5_lw", 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 0, r, e);
      check("p5_lw_v", r, 32'h10);

      op("p6_sw400", 1'b1, 32'h400, 2'b10, 1'b0, 32'hCAFEF00D, 0, r, e);
      op("p6_lw0", 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 0, r, e);
      check("p6_wrap", r, 32'hCAFEF00D);

      acc1 = 0;
      acc3 = 0;
      bad  = 0;
      a_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (a1_ready) acc1++;
         if (a3_ready) acc3++;
         if (a1_rv && (a1_rd !== 32'h1 || a1_err)) bad++;
         if (a3_rv && (a3_rd !== 32'h1 || a3_err)) bad++;
         @(posedge clk); #1;
      end
      a_valid = 1'b0;
      check("p6_l1_accepts", 32'(acc1), 32'd20);
      check("p6_l3_accepts", 32'(acc3), 32'd10);
      check("p6_aux_data", 32'(bad), 32'd0);

      for (int k = 0; k < 200; k++) begin
         t_we   = 1'($urandom);
         t_addr = $urandom & 32'hF000003F;
         t_sz   = 2'($urandom_range(0, 3));
         t_sgn  = 1'($urandom);
         t_wd   = $urandom;
         t_st   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         op($sformatf("rnd%0d", k), t_we, t_addr, t_sz, t_sgn, t_wd, t_st, r, e);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that serves load/store requests issued by the pipeline's memory stage over a valid/ready request channel and a valid/ready response channel.
- Replaces the zero-latency combinational data array with a multi-cycle, sized (byte/half/word) access.
- Supports one outstanding request and a parameterised access latency, so the pipeline can exercise stall logic.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two, >= 2.
- LATENCY, 2: cycles from request acceptance to response valid; >= 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  load data, extended to 32 bits; 0 for stores.
- rsp_err  out  1  access faulted.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, latency counter 0.
  - Memory contents are not reset.
  - Power-up contents: memory[i] = i.
- Indexing:
  - word index = req_addr[2 +: log2(DEPTH_WORDS)].
  - Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Byte order: big-endian. Byte offset 0 is bits 31:24. Half at offset 0 is bits 31:16; half at offset 2 is bits 15:0.
- Request fields are captured at the acceptance edge; later changes on req_* have no effect.
- req_ready = (state == IDLE), decoded combinationally from state.
- Acceptance happens when req_valid and req_ready are both 1 at a posedge.
- FSM:
  - IDLE: on acceptance, load counter with LATENCY-1. If LATENCY == 1, perform the access and go to RESP; otherwise go to BUSY.
  - BUSY: decrement the counter each cycle. When the counter is 1, perform the access at that edge and go to RESP.
  - RESP: rsp_valid = 1. When rsp_ready = 1, go to IDLE at that edge.
- Timing:
  - A request accepted at edge T shows rsp_valid high in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
  - Minimum spacing between accepted requests is LATENCY+1 cycles.
  - There is no combinational path from req_valid to rsp_valid.
- Store (performed at the access edge):
  - Only the addressed bytes are written; other bytes are preserved.
  - The write data comes from the low bytes of req_wdata.
- Load: read-after-write order is trivially guaranteed because only one request can be outstanding.
- Backpressure: while in RESP with rsp_ready = 0, rsp_valid, rsp_rdata and rsp_err hold stable, and req_valid is ignored.
- Reset mid-operation:
  - Any pending access is dropped; a store not yet performed leaves memory unchanged.
  - req_ready = 1 in the first cycle after rst deasserts.

Optional Feature:
DMEM_ALIGN_CHECK_EN
- Defined:
  - The following fault: half with addr[0] = 1; word with addr[1:0] != 0; size 11.
  - A faulting access responds with rsp_err = 1 and rsp_rdata = 0, and performs no memory write.
  - Response latency is unchanged.
- Undefined:
  - rsp_err is tied to 0.
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0].
  - Size 11 is treated as word.

Decomposition:
- Package dmem_pkg:
  - Size enum: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD.
  - FSM state enum: IDLE, BUSY, RESP.
  - Function extend(data, size, signed).
- Sub-module dmem_lane_align (combinational):
  - From size and offset, produces the 4-bit byte-enable and the merged write word.
  - Extracts and extends load data.
- The FSM and array stay in dmem_responder.

Test Plan:
1. After reset, lw 0x00000010 with req_signed = 0 → rsp_valid exactly 2 cycles after acceptance, rsp_rdata 0x00000004, rsp_err 0.
2. sw 0x11223344 @0x20, then lbu @0x21 → 0x00000022; lbu @0x23 → 0x00000044; sb 0x80 @0x20, then lb @0x20 → 0xFFFFFF80 and lw @0x20 → 0x80223344.
3. Hold rsp_ready = 0 for 3 cycles during a response while req_valid = 1 → rsp_valid/rsp_rdata stable, req_ready 0, no second acceptance; rsp_ready = 1 → IDLE next cycle.
4. With 0x11223344 stored @0x20, lw @0x22:
   - with macro → rsp_err 1, rsp_rdata 0;
   - without macro → rsp_rdata 0x11223344.
   - Also, under the macro, sh @0x21 leaves memory unchanged.
5. Assert rst while a sw 0xDEADBEEF @0x40 is in BUSY → a later lw @0x40 returns 0x00000010, rsp_valid 0 during reset, req_ready 1 in the first cycle after release.
6. Back-to-back loads with rsp_ready tied to 1, LATENCY = 1 and LATENCY = 3 → one accepted request every 2 and 4 cycles respectively; an address of 0x00000400 with DEPTH 256 wraps to word 0.
